ex_mem_stage: RTL and testbench

- Execute-to-memory stage directly downstream of the 16-bit ALU.
- Captures one executed instruction: ALU result, flags, store data, destination register and control bits.
- Drives the data-memory request handshake against a stalling memory.
- Presents the retired result to writeback and to the forwarding network.
- Holds at most one instruction. Applies backpressure to execute via in_ready.

---
 rtl/ex_mem_stage_pkg.sv | 30 +++
 rtl/ex_mem_stage_if.sv | 24 ++
 rtl/ex_mem_entry_reg.sv | 41 ++++
 rtl/ex_mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute-to-memory stage: FSM encodings,
// default widths and the layout of the single entry register E.
package ex_mem_stage_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int REG_AW_DEF = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT   = 2'd2,
      HALTED = 2'd3
   } state_t;

   // valid: slot holds a live instruction; done: result final, may retire/forward
   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic [DATA_W_DEF-1:0] data;
      logic [DATA_W_DEF-1:0] store;
      logic [REG_AW_DEF-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  halt;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/ex_mem_stage_if.sv
// Data-memory request bus between the EX/MEM stage (master) and memory (slave).
interface ex_mem_stage_if
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rd;
   logic              mem_wr;
   logic              mem_stall;
   logic              mem_done;

   modport master (
      output mem_addr, mem_wdata, mem_rd, mem_wr,
      input  mem_stall, mem_done, mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_rd, mem_wr,
      output mem_stall, mem_done, mem_rdata
   );
endinterface

// File: rtl/ex_mem_entry_reg.sv
// Entry register E for the EX/MEM stage, built from the shared enable dff cell.
// clr zeroes the whole record (used for reset and for squashed bubbles).

module dff_en #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // Synchronous clear, otherwise load when enabled
   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (en) q <= d;
   end
endmodule

module ex_mem_entry_reg
   import ex_mem_stage_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   clr,
   input  logic   en,
   input  entry_t d,
   output entry_t q
);
   logic [ENTRY_W-1:0] q_bits;

   dff_en #(.W(ENTRY_W)) u_dff (
      .clk (clk),
      .rst (rst | clr),
      .en  (en),
      .d   (d),
      .q   (q_bits)
   );

   assign q = entry_t'(q_bits);
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: holds one executed instruction, runs its data-memory
// access against a stalling memory, then retires it to writeback/forwarding.
// Optional overflow trap enabled by defining EX_MEM_OFL_TRAP_EN.
//
// state  | meaning
// IDLE   | accepting; E (if valid & done) retires this cycle
// REQ    | memory request strobe driven, waiting for it to be taken
// WAIT   | request taken, counting cycles until mem_done or timeout
// HALTED | halt retired; frozen until reset
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_AW  = REG_AW_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_ofl,
   input  logic [DATA_W-1:0] store_data,
   input  logic [REG_AW-1:0] rd,
   input  logic              reg_write,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              halt,
   ex_mem_stage_if.master    mem,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_AW-1:0] wb_rd,
   output logic              wb_reg_write,
   output logic              wb_halt,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_rd,
   output logic [DATA_W-1:0] fwd_data,
   output logic              err_timeout,
   output logic              err_ofl
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   entry_t           e_q;
   entry_t           e_d;
   logic             e_en;
   logic             e_clr;
   logic             retire;
   logic             halt_retire;
   logic             accept;
   logic             capture;
   logic             bubble;
   logic             is_mem_in;
   logic             ofl_trap;
   logic             mem_fin;
   logic             timeout;

   assign retire      = (state == IDLE) & e_q.valid & e_q.done;
   assign halt_retire = retire & e_q.halt;
   // A retiring halt closes the door in the same cycle so nothing younger is taken
   assign in_ready    = (state == IDLE) & ~halt_retire;
   assign accept      = in_valid & in_ready;
   assign capture     = accept & ~flush;
   assign bubble      = accept & flush;
   assign is_mem_in   = mem_read | mem_write;
   assign mem_fin     = ((state == REQ) & ~mem.mem_stall & mem.mem_done) |
                        ((state == WAIT) & mem.mem_done);
   assign timeout     = (state == WAIT) & ~mem.mem_done & (cnt == CNT_LAST);

`ifdef EX_MEM_OFL_TRAP_EN
   assign ofl_trap = alu_ofl & reg_write;
`else
   logic unused_ofl;
   assign unused_ofl = alu_ofl;
   assign ofl_trap   = 1'b0;
`endif

   // Next value of the entry record: capture, squash, retire or memory completion
   always_comb begin
      e_d   = e_q;
      e_en  = 1'b0;
      e_clr = 1'b0;
      if (capture) begin
         e_en        = 1'b1;
         e_d.valid   = 1'b1;
         e_d.done    = ~is_mem_in;
         e_d.data    = alu_out;
         e_d.store   = store_data;
         e_d.rd      = rd;
         e_d.reg_write = reg_write & ~mem_write & ~ofl_trap;
         e_d.mem_read  = mem_read;
         e_d.mem_write = mem_write;
         e_d.halt      = halt;
      end else if (bubble) begin
         e_clr = 1'b1;
      end else if (retire) begin
         e_en      = 1'b1;
         e_d.valid = 1'b0;
      end else if (mem_fin) begin
         e_en     = 1'b1;
         e_d.done = 1'b1;
         if (e_q.mem_read) e_d.data = mem.mem_rdata;
      end else if (timeout) begin
         e_en          = 1'b1;
         e_d.done      = 1'b1;
         e_d.reg_write = 1'b0;
      end
   end

   ex_mem_entry_reg u_entry (
      .clk (clk),
      .rst (rst),
      .clr (e_clr),
      .en  (e_en),
      .d   (e_d),
      .q   (e_q)
   );

   // Stage FSM with wait counter and sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (halt_retire)                state <= HALTED;
               else if (capture && is_mem_in)  state <= REQ;
            end
            REQ: begin
               if (!mem.mem_stall) begin
                  if (mem.mem_done) begin
                     state <= IDLE;
                  end else begin
                     state <= WAIT;
                     cnt   <= '0;
                  end
               end
            end
            WAIT: begin
               if (mem.mem_done) begin
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  state       <= IDLE;
                  err_timeout <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HALTED: state <= HALTED;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef EX_MEM_OFL_TRAP_EN
   // Sticky overflow-trap flag, set when a trapping instruction is captured
   always_ff @(posedge clk) begin
      if (rst)                      err_ofl <= 1'b0;
      else if (capture && ofl_trap) err_ofl <= 1'b1;
   end
`else
   assign err_ofl = 1'b0;
`endif

   assign mem.mem_rd    = (state == REQ) & e_q.mem_read;
   assign mem.mem_wr    = (state == REQ) & e_q.mem_write;
   assign mem.mem_addr  = (state == REQ) ? e_q.data  : '0;
   assign mem.mem_wdata = (state == REQ) ? e_q.store : '0;

   assign wb_valid     = retire;
   assign wb_data      = e_q.data;
   assign wb_rd        = e_q.rd;
   assign wb_reg_write = retire & e_q.reg_write;
   assign wb_halt      = retire & e_q.halt;

   assign fwd_valid = e_q.valid & e_q.done & e_q.reg_write;
   assign fwd_rd    = e_q.rd;
   assign fwd_data  = e_q.data;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;
   import ex_mem_stage_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [15:0] alu_out;
   logic        alu_ofl;
   logic [15:0] store_data;
   logic [2:0]  rd;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        halt;
   logic        wb_valid;
   logic [15:0] wb_data;
   logic [2:0]  wb_rd;
   logic        wb_reg_write;
   logic        wb_halt;
   logic        fwd_valid;
   logic [2:0]  fwd_rd;
   logic [15:0] fwd_data;
   logic        err_timeout;
   logic        err_ofl;

   int n_assert = 0;
   int n_fail   = 0;

   ex_mem_stage_if #(.DATA_W(16)) mif ();

   ex_mem_stage #(.DATA_W(16), .REG_AW(3), .TIMEOUT(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .flush        (flush),
      .alu_out      (alu_out),
      .alu_ofl      (alu_ofl),
      .store_data   (store_data),
      .rd           (rd),
      .reg_write    (reg_write),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .halt         (halt),
      .mem          (mif),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .wb_halt      (wb_halt),
      .fwd_valid    (fwd_valid),
      .fwd_rd       (fwd_rd),
      .fwd_data     (fwd_data),
      .err_timeout  (err_timeout),
      .err_ofl      (err_ofl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic f, input logic [15:0] a,
                        input logic [15:0] sd, input logic [2:0] r, input logic rw,
                        input logic mr, input logic mw, input logic h);
      in_valid   = v;
      flush      = f;
      alu_out    = a;
      store_data = sd;
      rd         = r;
      reg_write  = rw;
      mem_read   = mr;
      mem_write  = mw;
      halt       = h;
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_in_ready"},     in_ready,     1);
      chk({pfx, "_wb_valid"},     wb_valid,     0);
      chk({pfx, "_wb_rd"},        wb_rd,        0);
      chk({pfx, "_wb_reg_write"}, wb_reg_write, 0);
      chk({pfx, "_wb_halt"},      wb_halt,      0);
      chk({pfx, "_wb_data"},      wb_data,      0);
      chk({pfx, "_fwd_valid"},    fwd_valid,    0);
      chk({pfx, "_fwd_rd"},       fwd_rd,       0);
      chk({pfx, "_fwd_data"},     fwd_data,     0);
      chk({pfx, "_mem_rd"},       mif.mem_rd,   0);
      chk({pfx, "_mem_wr"},       mif.mem_wr,   0);
      chk({pfx, "_mem_addr"},     mif.mem_addr, 0);
      chk({pfx, "_mem_wdata"},    mif.mem_wdata, 0);
      chk({pfx, "_err_timeout"},  err_timeout,  0);
      chk({pfx, "_err_ofl"},      err_ofl,      0);
   endtask

   initial begin
      rst = 1'b1;
      alu_ofl = 1'b0;
      drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
      mif.mem_stall = 1'b0;
      mif.mem_done  = 1'b0;
      mif.mem_rdata = 16'h0;
      tick();
      tick();
      chk_reset("rst");
      rst = 1'b0;
      tick();

      // ALU op retires one cycle after capture, forwarding alongside
      drive(1, 0, 16'h1234, 16'h0, 3'd3, 1, 0, 0, 0);
      tick();
      drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
      chk("alu_wb_valid", wb_valid, 1);
      chk("alu_wb_data", wb_data, 16'h1234);
      chk("alu_wb_rd", wb_rd, 3);
      chk("alu_wb_reg_write", wb_reg_write, 1);
      chk("alu_fwd_valid", fwd_valid, 1);
      chk("alu_fwd_data", fwd_data, 16'h1234);
      chk("alu_fwd_rd", fwd_rd, 3);
      tick();
      chk("alu_retired_once", wb_valid, 0);

      // Overflowing ALU op: trapped only when the trap feature is built in
      alu_ofl = 1'b1;
      drive(1, 0, 16'h8000, 16'h0, 3'd6, 1, 0, 0, 0);
      tick();
      alu_ofl = 1'b0;
      drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
      chk("ofl_wb_valid", wb_valid, 1);
`ifdef EX_MEM_OFL_TRAP_EN
      chk("ofl_wb_reg_write", wb_reg_write, 0);
      chk("ofl_err_ofl", err_ofl, 1);
`else
      chk("ofl_wb_reg_write", wb_reg_write, 1);
      chk("ofl_err_ofl", err_ofl, 0);
`endif
      tick();

      // Load completing in the REQ cycle
      drive(1, 0, 16'h0040, 16'h0, 3'd5, 1, 1, 0, 0);
      tick();
      drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
      mif.mem_done  = 1'b1;
      mif.mem_rdata = 16'hBEEF;
      chk("ld_req_mem_rd", mif.mem_rd, 1);
      chk("ld_req_mem_addr", mif.mem_addr, 16'h0040);
      chk("ld_req_in_ready", in_ready, 0);
      chk("ld_req_wb_valid", wb_valid, 0);
      chk("ld_req_fwd_valid", fwd_valid, 0);
      tick();
      mif.mem_done = 1'b0;
      chk("ld_wb_valid", wb_valid, 1);
      chk("ld_wb_data", wb_data, 16'hBEEF);
      chk("ld_wb_rd", wb_rd, 5);
      chk("ld_mem_rd_dropped", mif.mem_rd, 0);
      tick();

      // Store: stalled 3 cycles, taken on 4th, done after 2 WAIT cycles
      drive(1, 0, 16'h0100, 16'hABCD, 3'd0, 0, 0, 1, 0);
      tick();
      drive(1, 0, 16'h5555, 16'h0, 3'd1, 1, 0, 0, 0);
      mif.mem_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mif.mem_stall = 1'b0;
         chk("st_mem_wr_held", mif.mem_wr, 1);
         chk("st_mem_wdata", mif.mem_wdata, 16'hABCD);
         chk("st_req_in_ready", in_ready, 0);
         tick();
      end
      chk("st_wait1_mem_wr", mif.mem_wr, 0);
      chk("st_wait1_wb_valid", wb_valid, 0);
      tick();
      chk("st_wait2_in_ready", in_ready, 0);
      mif.mem_done = 1'b1;
      tick();
      mif.mem_done = 1'b0;
      chk("st_wb_valid", wb_valid, 1);
      chk("st_wb_reg_write", wb_reg_write, 0);
      chk("st_in_ready", in_ready, 1);
      tick();
      drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
      chk("st_next_alu_wb_valid", wb_valid, 1);
      chk("st_next_alu_wb_data", wb_data, 16'h5555);
      tick();

      // Load never answered: abandoned after 64 WAIT cycles
      drive(1, 0, 16'h0200, 16'h0, 3'd2, 1, 1, 0, 0);
      tick();
      drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
      chk("to_req_mem_rd", mif.mem_rd, 1);
      tick();
      for (int i = 0; i < 63; i++) tick();
      chk("to_last_wait_err", err_timeout, 0);
      chk("to_last_wait_in_ready", in_ready, 0);
      tick();
      chk("to_err_timeout", err_timeout, 1);
      chk("to_wb_valid", wb_valid, 1);
      chk("to_wb_reg_write", wb_reg_write, 0);
      chk("to_fwd_valid", fwd_valid, 0);
      chk("to_in_ready", in_ready, 1);
      tick();

      // Flush in IDLE captures a bubble
      drive(1, 1, 16'h7777, 16'h0, 3'd7, 1, 0, 0, 0);
      tick();
      drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
      chk("fl_idle_wb_valid", wb_valid, 0);
      chk("fl_idle_fwd_valid", fwd_valid, 0);
      tick();

      // Flush during WAIT is ignored; pending load retires
      drive(1, 0, 16'h0300, 16'h0, 3'd4, 1, 1, 0, 0);
      tick();
      drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
      tick();
      drive(1, 1, 16'h1111, 16'h0, 3'd1, 1, 0, 0, 0);
      tick();
      drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
      mif.mem_done  = 1'b1;
      mif.mem_rdata = 16'hCAFE;
      tick();
      mif.mem_done = 1'b0;
      chk("fl_wait_wb_valid", wb_valid, 1);
      chk("fl_wait_wb_data", wb_data, 16'hCAFE);
      chk("fl_wait_wb_rd", wb_rd, 4);
      tick();

      // Halt followed by continuous in_valid
      drive(1, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 1);
      tick();
      drive(1, 0, 16'h2222, 16'h0, 3'd2, 1, 0, 0, 0);
      chk("halt_wb_valid", wb_valid, 1);
      chk("halt_wb_halt", wb_halt, 1);
      chk("halt_in_ready", in_ready, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("halted_in_ready", in_ready, 0);
         chk("halted_wb_valid", wb_valid, 0);
         chk("halted_wb_halt", wb_halt, 0);
      end
      rst = 1'b1;
      drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
      tick();
      chk_reset("rst2");
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
